// File: rtl/wbu_pkg.sv
// ---------------------------------------------------------------------------
// wbu_pkg : shared types and helpers for the writeback commit unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wbu_pkg;

  localparam int PID_W = 2;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic             we;
    logic [4:0]       addr;
    logic [XLEN-1:0]  data;
    logic [PID_W-1:0] pID;
  } wb_pkt_t;

  // pID arithmetic wraps naturally at the PID_W boundary.
  function automatic logic [PID_W-1:0] pid_inc(input logic [PID_W-1:0] pid,
                                               input logic [PID_W-1:0] n);
    return pid + n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wbu_commit_slot.sv
// ---------------------------------------------------------------------------
// wbu_commit_slot : single-entry holding register for one WBU way
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wbu_commit_slot
  import wbu_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    valid_i,
  input  wb_pkt_t pkt_i,
  input  logic    commit_i,
  input  logic    flush_i,
  output logic    ready_o,
  output logic    valid_o,
  output wb_pkt_t pkt_o
);

  logic    valid_q, valid_d;
  wb_pkt_t pkt_q, pkt_d;

  // A committing entry frees the slot at the same edge, so refill is bubble-free.
  assign ready_o = (~valid_q | commit_i) & ~flush_i;
  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (valid_i && ready_o) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
    end else if (commit_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wbu_commit_unit.sv
// ---------------------------------------------------------------------------
// wbu_commit_unit : in-order two-way writeback commit to the integer regfile
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wbu_commit_unit
  import wbu_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             way0_valid_i,
  input  logic             way0_rdWriteEnable_i,
  input  logic [4:0]       way0_rdAddr_i,
  input  logic [XLEN-1:0]  way0_rdData_i,
  input  logic [PID_W-1:0] way0_pID_i,
  output logic             way0_ready_o,
  input  logic             way1_valid_i,
  input  logic             way1_rdWriteEnable_i,
  input  logic [4:0]       way1_rdAddr_i,
  input  logic [XLEN-1:0]  way1_rdData_i,
  input  logic [PID_W-1:0] way1_pID_i,
  output logic             way1_ready_o,
  input  logic             flush_i,
  input  logic [PID_W-1:0] flushPID_i,
  output logic             wr0_en_o,
  output logic [4:0]       wr0_addr_o,
  output logic [XLEN-1:0]  wr0_data_o,
  output logic             wr1_en_o,
  output logic [4:0]       wr1_addr_o,
  output logic [XLEN-1:0]  wr1_data_o,
  output logic [1:0]       retire_o,
  output logic             error_o
);

  wb_pkt_t          in0, in1, s0, s1, older, younger;
  logic             v0, v1, commit0, commit1;
  logic             old_is0, old_is1, young_match, old_c, young_c;
  logic             old_wen, young_wen, err_now;
  logic [PID_W-1:0] next_pid_q, next_pid_d, pid_p1;
  logic             error_q, error_d;

  assign in0 = '{we: way0_rdWriteEnable_i, addr: way0_rdAddr_i, data: way0_rdData_i, pID: way0_pID_i};
  assign in1 = '{we: way1_rdWriteEnable_i, addr: way1_rdAddr_i, data: way1_rdData_i, pID: way1_pID_i};

  wbu_commit_slot u_slot0 (
    .clk(clk), .reset_n(reset_n), .valid_i(way0_valid_i), .pkt_i(in0),
    .commit_i(commit0), .flush_i(flush_i), .ready_o(way0_ready_o),
    .valid_o(v0), .pkt_o(s0)
  );

  wbu_commit_slot u_slot1 (
    .clk(clk), .reset_n(reset_n), .valid_i(way1_valid_i), .pkt_i(in1),
    .commit_i(commit1), .flush_i(flush_i), .ready_o(way1_ready_o),
    .valid_o(v1), .pkt_o(s1)
  );

  assign pid_p1 = pid_inc(next_pid_q, PID_W'(1));

  // Slot 0 is preferred as older if both (erroneously) carry nextPID.
  assign old_is0     = v0 && (s0.pID == next_pid_q);
  assign old_is1     = !old_is0 && v1 && (s1.pID == next_pid_q);
  assign young_match = old_is0 ? (v1 && (s1.pID == pid_p1)) :
                       old_is1 ? (v0 && (s0.pID == pid_p1)) : 1'b0;
  assign old_c       = ~flush_i & (old_is0 | old_is1);
  assign young_c     = old_c & young_match;
  assign commit0     = (old_c & old_is0) | (young_c & old_is1);
  assign commit1     = (old_c & old_is1) | (young_c & old_is0);

  assign older   = old_is0 ? s0 : s1;
  assign younger = old_is0 ? s1 : s0;

  assign old_wen   = old_c & older.we & (older.addr != 5'd0);
  assign young_wen = young_c & younger.we & (younger.addr != 5'd0);

  // Same-destination pair: the younger value is the architectural result.
  assign wr0_en_o   = old_wen & ~(young_wen && (older.addr == younger.addr));
  assign wr0_addr_o = older.addr;
  assign wr0_data_o = older.data;
  assign wr1_en_o   = young_wen;
  assign wr1_addr_o = younger.addr;
  assign wr1_data_o = younger.data;
  assign retire_o   = {1'b0, old_c} + {1'b0, young_c};

  assign next_pid_d = flush_i ? flushPID_i : pid_inc(next_pid_q, PID_W'(retire_o));

  assign err_now = (v0 && v1 && (s0.pID == s1.pID)) ||
                   (v0 && (s0.pID != next_pid_q) && (s0.pID != pid_p1)) ||
                   (v1 && (s1.pID != next_pid_q) && (s1.pID != pid_p1));
  assign error_d = error_q | err_now;
  assign error_o = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_pid_q <= '0;
      error_q    <= 1'b0;
    end else begin
      next_pid_q <= next_pid_d;
      error_q    <= error_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wbu_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_wbu_commit_unit : directed table-driven bench for wbu_commit_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wbu_commit_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v0, we0, v1, we1, fl;
  logic [4:0]  a0, a1;
  logic [63:0] d0, d1;
  logic [1:0]  p0, p1, fp;
  logic        rdy0, rdy1, e0, e1, err;
  logic [4:0]  wa0, wa1;
  logic [63:0] wd0, wd1;
  logic [1:0]  ret;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wbu_commit_unit dut (
    .clk(clk), .reset_n(reset_n),
    .way0_valid_i(v0), .way0_rdWriteEnable_i(we0), .way0_rdAddr_i(a0),
    .way0_rdData_i(d0), .way0_pID_i(p0), .way0_ready_o(rdy0),
    .way1_valid_i(v1), .way1_rdWriteEnable_i(we1), .way1_rdAddr_i(a1),
    .way1_rdData_i(d1), .way1_pID_i(p1), .way1_ready_o(rdy1),
    .flush_i(fl), .flushPID_i(fp),
    .wr0_en_o(e0), .wr0_addr_o(wa0), .wr0_data_o(wd0),
    .wr1_en_o(e1), .wr1_addr_o(wa1), .wr1_data_o(wd1),
    .retire_o(ret), .error_o(err)
  );

  typedef struct {
    logic v0, we0; logic [4:0] a0; logic [63:0] d0; logic [1:0] p0;
    logic v1, we1; logic [4:0] a1; logic [63:0] d1; logic [1:0] p1;
    logic fl; logic [1:0] fp;
    logic r0, r1;
    logic e0; logic [4:0] ea0; logic [63:0] ed0;
    logic e1; logic [4:0] ea1; logic [63:0] ed1;
    logic [1:0] ret; logic err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv0, iwe0, input logic [4:0] ia0, input logic [63:0] id0, input logic [1:0] ip0,
                     input logic iv1, iwe1, input logic [4:0] ia1, input logic [63:0] id1, input logic [1:0] ip1,
                     input logic ifl, input logic [1:0] ifp, input logic xr0, xr1,
                     input logic xe0, input logic [4:0] xa0, input logic [63:0] xd0,
                     input logic xe1, input logic [4:0] xa1, input logic [63:0] xd1,
                     input logic [1:0] xret, input logic xerr);
    vec_t v;
    v.v0 = iv0; v.we0 = iwe0; v.a0 = ia0; v.d0 = id0; v.p0 = ip0;
    v.v1 = iv1; v.we1 = iwe1; v.a1 = ia1; v.d1 = id1; v.p1 = ip1;
    v.fl = ifl; v.fp = ifp; v.r0 = xr0; v.r1 = xr1;
    v.e0 = xe0; v.ea0 = xa0; v.ed0 = xd0; v.e1 = xe1; v.ea1 = xa1; v.ed1 = xd1;
    v.ret = xret; v.err = xerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    v0 = v.v0; we0 = v.we0; a0 = v.a0; d0 = v.d0; p0 = v.p0;
    v1 = v.v1; we1 = v.we1; a1 = v.a1; d1 = v.d1; p1 = v.p1;
    fl = v.fl; fp = v.fp;
  endtask

  task automatic idle();
    v0 = 0; we0 = 0; a0 = 0; d0 = 0; p0 = 0;
    v1 = 0; we1 = 0; a1 = 0; d1 = 0; p1 = 0;
    fl = 0; fp = 0;
  endtask

  task automatic compare(input vec_t v, input int idx);
    check("way0_ready", idx, 64'(rdy0), 64'(v.r0));
    check("way1_ready", idx, 64'(rdy1), 64'(v.r1));
    check("wr0_en", idx, 64'(e0), 64'(v.e0));
    check("wr1_en", idx, 64'(e1), 64'(v.e1));
    check("retire", idx, 64'(ret), 64'(v.ret));
    check("error", idx, 64'(err), 64'(v.err));
    if (v.e0) begin
      check("wr0_addr", idx, 64'(wa0), 64'(v.ea0));
      check("wr0_data", idx, wd0, v.ed0);
    end
    if (v.e1) begin
      check("wr1_addr", idx, 64'(wa1), 64'(v.ea1));
      check("wr1_data", idx, wd1, v.ed1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    //   way0 {v,we,a,d,p}      way1 {v,we,a,d,p}       fl fp  rdy    wr0          wr1           ret err
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 0,0,0,       0,0,0,        0,0); // reset idle
    add(1,1,5,'hAA,0,          0,0,0,0,0,              0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(1,1,3,'h33,1,          1,1,4,'h44,2,           0,0, 1,1, 1,5,'hAA,    0,0,0,        1,0); // commit + refill
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 1,3,'h33,    1,4,'h44,     2,0);
    add(0,0,0,0,0,             1,1,9,'h99,0,           0,0, 1,1, 0,0,0,       0,0,0,        0,0); // younger first
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,0, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,0, 0,0,0,       0,0,0,        0,0);
    add(1,1,8,'h88,3,          0,0,0,0,0,              0,0, 1,0, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 1,8,'h88,    1,9,'h99,     2,0); // wrap 3->0
    add(1,1,7,'h71,1,          1,1,7,'h72,2,           0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 0,0,0,       1,7,'h72,     2,0); // collision
    add(1,1,0,5,3,             1,1,0,6,0,              0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 0,0,0,       0,0,0,        2,0); // x0 targets
    add(1,0,2,1,1,             1,1,10,'hA0,2,          0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 0,0,0,       1,10,'hA0,    2,0); // we=0 older
    add(1,1,11,'hB,3,          1,1,12,'hC,0,           0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(1,1,13,'hD,3,          0,0,0,0,0,              1,2, 0,0, 0,0,0,       0,0,0,        0,0); // flush
    add(1,1,14,'hE,2,          0,0,0,0,0,              0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 1,14,'hE,    0,0,0,        1,0); // nextPID=2
    add(1,1,1,1,3,             1,1,2,2,3,              0,0, 1,1, 0,0,0,       0,0,0,        0,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,0, 1,1,1,       0,0,0,        1,0);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,0, 0,0,0,       0,0,0,        0,1); // duplicate pID
    add(0,0,0,0,0,             0,0,0,0,0,              1,2, 0,0, 0,0,0,       0,0,0,        0,1);
    add(0,0,0,0,0,             1,1,3,'h3C,2,           0,0, 1,1, 0,0,0,       0,0,0,        0,1);
    add(0,0,0,0,0,             0,0,0,0,0,              0,0, 1,1, 1,3,'h3C,    0,0,0,        1,1); // older in way1

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      compare(vecs[i], i);
    end

    // Reset in the middle of operation drops the held packet.
    @(posedge clk); #1;
    idle(); v0 = 1; we0 = 1; a0 = 5'd20; d0 = 64'h2020; p0 = 2'd3;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check("rst_wr0_en", 100, 64'(e0), 64'd0);
    check("rst_retire", 100, 64'(ret), 64'd0);
    check("rst_error", 100, 64'(err), 64'd0);
    check("rst_ready0", 100, 64'(rdy0), 64'd1);
    check("rst_ready1", 100, 64'(rdy1), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_wr0_en", 101, 64'(e0), 64'd0);
      check("post_rst_retire", 101, 64'(ret), 64'd0);
    end

    // Flush to pID 2, then load both ways with pID 2.
    @(posedge clk); #1;
    idle(); fl = 1; fp = 2'd2;
    @(posedge clk); #1;
    idle(); v0 = 1; we0 = 1; a0 = 5'd1; d0 = 64'h1; p0 = 2'd2;
    v1 = 1; we1 = 1; a1 = 5'd2; d1 = 64'h2; p1 = 2'd2;
    @(negedge clk);
    check("dup_err_before", 102, 64'(err), 64'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("dup_wr0_en", 103, 64'(e0), 64'd1);
    check("dup_wr0_addr", 103, 64'(wa0), 64'd1);
    check("dup_retire", 103, 64'(ret), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      idle(); fl = (k == 2);
      @(negedge clk);
      check("dup_err_sticky", 104 + k, 64'(err), 64'd1);
    end
    @(posedge clk); #1;
    idle();
    reset_n = 1'b0;
    #2;
    check("err_cleared_by_reset", 110, 64'(err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("err_after_reset", 111, 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wbu_commit_unit.md
# wbu_commit_unit

Consumes the writeback packets emitted by the two per-way WBU pipeline registers (way0, way1) and commits them to the integer register file in program order, using the 2-bit pipeline ID (pID) carried with each packet. It buffers one packet per way, drives two register-file write ports per cycle, and returns `ready` to each WBU register. It sits between the WBU registers and the regfile write side and is the only writer of the regfile.

## Interface
- `PID_W`, 2: pipeline-ID width; pID space wraps modulo 2^PID_W.
- `XLEN`, 64: data width.
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: core clock.
- `reset_n` in 1: async active-low reset.
- `way0_valid_i`, `way1_valid_i` in 1: packet present from WBU register of that way.
- `way0_rdWriteEnable_i`, `way1_rdWriteEnable_i` in 1: packet writes rd.
- `way0_rdAddr_i`, `way1_rdAddr_i` in 5: destination register.
- `way0_rdData_i`, `way1_rdData_i` in XLEN: writeback data.
- `way0_pID_i`, `way1_pID_i` in PID_W: program-order ID.
- `way0_ready_o`, `way1_ready_o` out 1: slot can accept this cycle.
- `flush_i` in 1: discard all held packets.
- `flushPID_i` in PID_W: next expected pID after flush.
- `wr0_en_o`, `wr1_en_o` out 1: regfile write enables (wr0 older, wr1 younger).
- `wr0_addr_o`, `wr1_addr_o` out 5: write addresses.
- `wr0_data_o`, `wr1_data_o` out XLEN: write data.
- `retire_o` out 2: packets committed this cycle (0, 1, 2).
- `error_o` out 1: sticky protocol error.

## Operation
- Per way, one holding slot (valid, we, addr, data, pID). Capture on edge when `valid_i && ready_o`.
- `nextPID` register: pID of oldest uncommitted packet.
- Commit selection (combinational from slots): older = slot with pID == nextPID; younger = other slot if valid and pID == nextPID+1 (mod 2^PID_W). Younger commits only if older commits same cycle.
- On commit: `nextPID += retire_o` (wraps); committed slots clear.
- `ready_o` = slot empty OR slot committing this cycle, AND `~flush_i` (bypass-refill allowed same edge).
- Write-port rules: wrN_en = slot committing && we && addr != 0. If both commit, both enabled and addresses equal, wr0_en forced 0 (younger wins).
- Packet with `we`=0 still commits (retire counted, no write).
- `flush_i`: on edge, both slots cleared, nextPID ← flushPID_i, inputs ignored, no commit that cycle (wr*_en_o, retire_o = 0 while flush_i high).
- `error_o` set (sticky until reset) when: both slots valid with equal pID; or a valid slot’s pID is neither nextPID nor nextPID+1.

## Timing
- Reset: slots empty, nextPID=0, error_o=0; all wr*/retire outputs 0, both ready_o=1.
- Latency: packet accepted at edge E appears on wr port in cycle after E; regfile updates at edge E+1. Zero-bubble: slot may commit and refill at same edge.
- Write/retire outputs combinational from registered slot state and flush_i; no input-to-output combinational path except through flush_i and the ready_o refill term.
- Out-of-order arrival: slot holding nextPID+1 waits (ready_o=0) until nextPID arrives in other slot.
- nextPID wrap 3→0 seamless; younger match computed modulo.
- Reset mid-operation: held packets dropped, no writes issued.

## Structure
- `wbu_pkg`: `PID_W`, `XLEN`, `wb_pkt_t` struct {we, addr[4:0], data[XLEN-1:0], pID}, `pid_inc` function (modulo add).
- Sub-module `wbu_commit_slot`: one holding register with capture/clear/ready logic; instantiated per way. Top holds nextPID, selection, write-port collision and error logic.

## Test plan
- Reset, then way0 pID0 {we=1, x5, 0xAA} -> next cycle wr0_en=1 addr=5 data=0xAA, retire=1, nextPID=1.
- Same cycle way0 pID1 x3, way1 pID2 x4 (nextPID=1) -> wr0=x3, wr1=x4 same cycle, retire=2, nextPID=3.
- Way1 pID1 arrives first, way0 pID0 two cycles later -> way1_ready_o=0 meanwhile, then wr0=way0, wr1=way1 together.
- Both commit with rdAddr=7 -> wr0_en=0, wr1_en=1 data=younger; rdAddr=0 -> no enable, retire still 2.
- nextPID=3, packets pID3 and pID0 -> both commit, nextPID=1; flush_i with flushPID_i=2 while slots full -> no writes, slots empty, nextPID=2.
- Both slots pID2 -> error_o=1 and stays 1 until reset_n low.
